// File: rtl/wb_bram_pkg.sv
// ---------------------------------------------------------------------------
// wb_bram_pkg
// Shared types and constants for the Wishbone burst block RAM:
//   cti_e   - Wishbone cycle-type identifiers used by the read FSM
//   bte_e   - Wishbone burst-type extensions (linear / wrap-4 / -8 / -16)
//   state_e - read FSM state encoding
//   WRAP*_MASK - low word-index bits that wrap for each wrapping burst type
// ---------------------------------------------------------------------------
package wb_bram_pkg;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_CONST   = 3'b001,
    CTI_INCR    = 3'b010,
    CTI_END     = 3'b111
  } cti_e;

  typedef enum logic [1:0] {
    BTE_LINEAR = 2'b00,
    BTE_WRAP4  = 2'b01,
    BTE_WRAP8  = 2'b10,
    BTE_WRAP16 = 2'b11
  } bte_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLASSIC,
    ST_BURST
  } state_e;

  localparam logic [3:0] WRAP4_MASK  = 4'h3;
  localparam logic [3:0] WRAP8_MASK  = 4'h7;
  localparam logic [3:0] WRAP16_MASK = 4'hF;

  // Constant-address and incrementing cycles both stream one beat per cycle.
  function automatic logic is_burst_cti(input logic [2:0] cti);
    return (cti == CTI_INCR) || (cti == CTI_CONST);
  endfunction

endpackage

// File: rtl/wb_burst_adr_gen.sv
// ---------------------------------------------------------------------------
// wb_burst_adr_gen
// Next word index for a Wishbone burst. Linear bursts roll over the whole
// memory; wrapping bursts wrap only the low 2/3/4 bits and hold the rest.
// A constant-address cycle freezes the index.
// Ports:
//   cur_idx  in  ADR_WIDTH  current word index
//   bte      in  2          burst-type extension
//   cti      in  3          cycle-type identifier of the acked beat
//   next_idx out ADR_WIDTH  word index for the following beat
// ---------------------------------------------------------------------------
module wb_burst_adr_gen
  import wb_bram_pkg::*;
#(
  parameter int ADR_WIDTH = 11
) (
  input  logic [ADR_WIDTH-1:0] cur_idx,
  input  logic [1:0]           bte,
  input  logic [2:0]           cti,
  output logic [ADR_WIDTH-1:0] next_idx
);

  logic [ADR_WIDTH-1:0] inc_idx;
  logic [ADR_WIDTH-1:0] wrap_mask;

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    inc_idx   = cur_idx + ADR_WIDTH'(1);
    wrap_mask = {ADR_WIDTH{1'b1}};
    case (bte)
      BTE_WRAP4:  wrap_mask = ADR_WIDTH'(WRAP4_MASK);
      BTE_WRAP8:  wrap_mask = ADR_WIDTH'(WRAP8_MASK);
      BTE_WRAP16: wrap_mask = ADR_WIDTH'(WRAP16_MASK);
      default:    wrap_mask = {ADR_WIDTH{1'b1}};
    endcase
    if (cti == CTI_CONST) begin
      next_idx = cur_idx;
    end else begin
      next_idx = (cur_idx & ~wrap_mask) | (inc_idx & wrap_mask);
    end
  end

endmodule

// File: rtl/wb_bram_burst.sv
// ---------------------------------------------------------------------------
// wb_bram_burst
// Wishbone B4 block-RAM slave with byte-lane writes, classic reads and
// zero-wait-state incrementing / wrapping / constant-address read bursts.
// Writes are acked combinationally; reads are acked from the registered
// ack_q one cycle after the request and then once per cycle in a burst.
//
// Ports:
//   clk        in   1              clock, rising edge
//   rst_n      in   1              asynchronous active-low reset
//   wb_adr     in   32             byte address
//   wb_dat_ms  in   8*DATA_BYTES   write data
//   wb_dat_sm  out  8*DATA_BYTES   read data (unselected lanes read 0)
//   wb_sel     in   DATA_BYTES     byte-lane enables
//   wb_cyc, wb_stb, wb_we  in 1    bus qualifiers
//   wb_cti     in   3              cycle-type identifier
//   wb_bte     in   2              burst-type extension
//   wb_ack     out  1              normal termination
//   wb_err     out  1              error termination
//
// Build option: define WB_BRAM_BURST_ERR_EN to terminate accesses whose
// address has any bit set above the word-index MSB with wb_err instead of
// wb_ack. Without it those bits are ignored and wb_err stays 0.
// ---------------------------------------------------------------------------
module wb_bram_burst
  import wb_bram_pkg::*;
#(
  parameter int DATA_BYTES    = 4,
  parameter int MEM_ADR_WIDTH = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             wb_adr,
  input  logic [8*DATA_BYTES-1:0] wb_dat_ms,
  output logic [8*DATA_BYTES-1:0] wb_dat_sm,
  input  logic [DATA_BYTES-1:0]   wb_sel,
  input  logic                    wb_cyc,
  input  logic                    wb_stb,
  input  logic                    wb_we,
  input  logic [2:0]              wb_cti,
  input  logic [1:0]              wb_bte,
  output logic                    wb_ack,
  output logic                    wb_err
);

  localparam int LB    = $clog2(DATA_BYTES);
  localparam int DW    = 8 * DATA_BYTES;
  localparam int AW    = MEM_ADR_WIDTH;
  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];

  state_e        state;
  logic          ack_q;
  logic          err_q;
  logic [AW-1:0] cnt;
  logic [AW-1:0] next_idx;
  logic [AW-1:0] adr_idx;
  logic [AW-1:0] rd_idx;
  logic [DW-1:0] rd_word;
  logic [DW-1:0] rd_lanes;
  logic          req;
  logic          adr_err;
  logic          wr_en;
  logic          unused_adr;

  assign req        = wb_cyc & wb_stb;
  assign adr_idx    = wb_adr[AW+LB-1:LB];
  assign unused_adr = ^wb_adr;

`ifdef WB_BRAM_BURST_ERR_EN
  if (AW + LB < 32) begin : g_adr_chk
    assign adr_err = |wb_adr[31:AW+LB];
  end else begin : g_adr_full
    assign adr_err = 1'b0;
  end
`else
  assign adr_err = 1'b0;
`endif

  assign wr_en  = req & wb_we & ~adr_err;
  assign wb_ack = req & (wb_we ? ~adr_err : ack_q);
  assign wb_err = req & (wb_we ?  adr_err : err_q);

  wb_burst_adr_gen #(
    .ADR_WIDTH (AW)
  ) u_adr_gen (
    .cur_idx  (cnt),
    .bte      (wb_bte),
    .cti      (wb_cti),
    .next_idx (next_idx)
  );

  // Single read port: the starting address when idle, the advanced index on
  // an acked burst beat, and the held index when resuming after a wait state.
  always_comb begin
    rd_idx = adr_idx;
    if (state == ST_BURST) begin
      rd_idx = ack_q ? next_idx : cnt;
    end
  end

  assign rd_word = mem[rd_idx];

  always_comb begin
    rd_lanes = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      rd_lanes[8*i +: 8] = wb_sel[i] ? rd_word[8*i +: 8] : 8'h00;
    end
  end

  // NOTE: the RAM array has no reset so it maps onto block RAM; its contents
  // survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (wb_sel[i]) begin
          mem[adr_idx][8*i +: 8] <= wb_dat_ms[8*i +: 8];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      cnt       <= '0;
      wb_dat_sm <= '0;
    end else if (!wb_cyc) begin
      // Cycle abandoned: drop any pending beat.
      state <= ST_IDLE;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else if (wb_stb && wb_we) begin
      // A write aborts any read in progress; it is acked combinationally.
      state <= ST_IDLE;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wb_stb) begin
            if (err_q) begin
              err_q <= 1'b0;  // error beat terminates this cycle
            end else if (adr_err) begin
              err_q     <= 1'b1;
              wb_dat_sm <= '0;
            end else begin
              ack_q     <= 1'b1;
              cnt       <= adr_idx;
              wb_dat_sm <= rd_lanes;
              state     <= is_burst_cti(wb_cti) ? ST_BURST : ST_CLASSIC;
            end
          end
        end

        ST_CLASSIC: begin
          if (wb_stb) begin
            state <= ST_IDLE;
            ack_q <= 1'b0;
          end
        end

        ST_BURST: begin
          if (!wb_stb) begin
            ack_q <= 1'b0;  // master wait state: hold index and data
          end else if (!ack_q) begin
            ack_q     <= 1'b1;  // strobe returned: re-present held word
            wb_dat_sm <= rd_lanes;
          end else if (is_burst_cti(wb_cti)) begin
            cnt       <= next_idx;
            wb_dat_sm <= rd_lanes;
          end else begin
            state <= ST_IDLE;  // end-of-burst beat acked this cycle
            ack_q <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          ack_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bram_burst.sv
// ---------------------------------------------------------------------------
// tb_wb_bram_burst
// Directed testbench for wb_bram_burst (DATA_BYTES=4, MEM_ADR_WIDTH=11).
// Each scenario task drives the bus and compares outputs against
// hand-computed values. Inputs change 1 ns after the rising edge; outputs
// are sampled 2 ns after the rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_bram_burst;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_ms;
  logic [31:0] wb_dat_sm;
  logic [3:0]  wb_sel;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [2:0]  wb_cti;
  logic [1:0]  wb_bte;
  logic        wb_ack;
  logic        wb_err;

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_beats [4];

  always #5 clk = ~clk;

  wb_bram_burst #(
    .DATA_BYTES    (4),
    .MEM_ADR_WIDTH (11)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_adr    (wb_adr),
    .wb_dat_ms (wb_dat_ms),
    .wb_dat_sm (wb_dat_sm),
    .wb_sel    (wb_sel),
    .wb_cyc    (wb_cyc),
    .wb_stb    (wb_stb),
    .wb_we     (wb_we),
    .wb_cti    (wb_cti),
    .wb_bte    (wb_bte),
    .wb_ack    (wb_ack),
    .wb_err    (wb_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    wb_cyc    = 1'b0;
    wb_stb    = 1'b0;
    wb_we     = 1'b0;
    wb_sel    = 4'h0;
    wb_cti    = 3'b000;
    wb_bte    = 2'b00;
    wb_adr    = 32'h0;
    wb_dat_ms = 32'h0;
  endtask

  task automatic do_write(input string name, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel,
                          input logic exp_err);
    step();
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_cti = 3'b000;
    wb_adr = adr; wb_dat_ms = dat; wb_sel = sel;
    #1;
    total++;
    if (wb_ack !== !exp_err) $display("FAIL %s ack: got %b want %b", name, wb_ack, !exp_err);
    else passed++;
    total++;
    if (wb_err !== exp_err) $display("FAIL %s err: got %b want %b", name, wb_err, exp_err);
    else passed++;
    step();
    bus_idle();
  endtask

  task automatic do_read(input string name, input logic [31:0] adr,
                         input logic [3:0] sel, input logic [2:0] cti,
                         input logic [31:0] exp, input logic exp_err);
    step();
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_cti = cti;
    wb_adr = adr; wb_sel = sel;
    #1;
    total++;
    if (wb_ack !== 1'b0 || wb_err !== 1'b0)
      $display("FAIL %s req_cycle: got ack=%b err=%b want 0/0", name, wb_ack, wb_err);
    else passed++;
    step();
    #1;
    total++;
    if (wb_ack !== !exp_err || wb_err !== exp_err)
      $display("FAIL %s term: got ack=%b err=%b want %b/%b", name, wb_ack, wb_err, !exp_err, exp_err);
    else passed++;
    total++;
    if (wb_dat_sm !== exp) $display("FAIL %s data: got %h want %h", name, wb_dat_sm, exp);
    else passed++;
    step();
    bus_idle();
  endtask

  task automatic run_burst(input string name, input int start,
                           input logic [1:0] bte, input logic [2:0] cti_run,
                           input int beats);
    step();
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 4'hF;
    wb_adr = 32'(start * 4); wb_cti = cti_run; wb_bte = bte;
    #1;
    total++;
    if (wb_ack !== 1'b0) $display("FAIL %s req_ack: got %b want 0", name, wb_ack);
    else passed++;
    for (int b = 0; b < beats; b++) begin
      step();
      wb_cti = (b == beats - 1) ? 3'b111 : cti_run;
      #1;
      total++;
      if (wb_ack !== 1'b1) $display("FAIL %s beat%0d_ack: got %b want 1", name, b, wb_ack);
      else passed++;
      total++;
      if (wb_dat_sm !== exp_beats[b])
        $display("FAIL %s beat%0d_data: got %h want %h", name, b, wb_dat_sm, exp_beats[b]);
      else passed++;
    end
    step();
    #1;
    total++;
    if (wb_ack !== 1'b0) $display("FAIL %s extra_ack: got %b want 0", name, wb_ack);
    else passed++;
    step();
    bus_idle();
  endtask

  task automatic test_reset();
    bus_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1;
    #2;
    total++;
    if (wb_ack !== 1'b0) $display("FAIL rst_ack: got %b want 0", wb_ack);
    else passed++;
    total++;
    if (wb_err !== 1'b0) $display("FAIL rst_err: got %b want 0", wb_err);
    else passed++;
    total++;
    if (wb_dat_sm !== 32'h0) $display("FAIL rst_dat: got %h want 0", wb_dat_sm);
    else passed++;
    bus_idle();
    #1 rst_n = 1'b1;
  endtask

  task automatic test_classic();
    do_write("wr_beef", 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    do_read("rd_sel0100", 32'h10, 4'b0100, 3'b000, 32'h00AD0000, 1'b0);
    do_read("rd_sel1001", 32'h10, 4'b1001, 3'b111, 32'hDE0000EF, 1'b0);
    do_write("wr_lane1", 32'h10, 32'h12345678, 4'b0010, 1'b0);
    do_write("wr_sel0", 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b0);
    do_read("rd_partial", 32'h10, 4'hF, 3'b000, 32'hDEAD56EF, 1'b0);
  endtask

  task automatic test_no_double_ack();
    step();
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 4'hF;
    wb_adr = 32'h10; wb_cti = 3'b000;
    #1;
    total++;
    if (wb_ack !== 1'b0) $display("FAIL hold_req: got %b want 0", wb_ack);
    else passed++;
    step(); #1;
    total++;
    if (wb_ack !== 1'b1) $display("FAIL hold_ack: got %b want 1", wb_ack);
    else passed++;
    step(); #1;
    total++;
    if (wb_ack !== 1'b0) $display("FAIL hold_second_ack: got %b want 0", wb_ack);
    else passed++;
    step();
    bus_idle();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      do_write("fill", 32'(i * 4), 32'(i), 4'hF, 1'b0);
    end
    do_write("fill_last", 32'h1FFC, 32'hA5A507FF, 4'hF, 1'b0);
  endtask

  task automatic test_wrap_bursts();
    exp_beats[0] = 32'd6; exp_beats[1] = 32'd7; exp_beats[2] = 32'd4; exp_beats[3] = 32'd5;
    run_burst("wrap4", 6, 2'b01, 3'b010, 4);
    exp_beats[0] = 32'd5; exp_beats[1] = 32'd6; exp_beats[2] = 32'd7; exp_beats[3] = 32'd0;
    run_burst("wrap8", 5, 2'b10, 3'b010, 4);
  endtask

  task automatic test_linear_end();
    exp_beats[0] = 32'hA5A507FF; exp_beats[1] = 32'd0; exp_beats[2] = 32'd1; exp_beats[3] = 32'd0;
    run_burst("linear_end", 2047, 2'b00, 3'b010, 3);
  endtask

  task automatic test_const_burst();
    exp_beats[0] = 32'd3; exp_beats[1] = 32'd3; exp_beats[2] = 32'd3; exp_beats[3] = 32'd0;
    run_burst("const", 3, 2'b00, 3'b001, 3);
  endtask

  task automatic test_wait_state();
    step();
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 4'hF;
    wb_adr = 32'h8; wb_cti = 3'b010; wb_bte = 2'b00;
    #1;
    step(); #1;
    total++;
    if (wb_ack !== 1'b1 || wb_dat_sm !== 32'd2)
      $display("FAIL ws_beat0: got ack=%b dat=%h want 1/2", wb_ack, wb_dat_sm);
    else passed++;
    step(); #1;
    total++;
    if (wb_ack !== 1'b1 || wb_dat_sm !== 32'd3)
      $display("FAIL ws_beat1: got ack=%b dat=%h want 1/3", wb_ack, wb_dat_sm);
    else passed++;
    step(); wb_stb = 1'b0; #1;
    total++;
    if (wb_ack !== 1'b0) $display("FAIL ws_gap1: got %b want 0", wb_ack);
    else passed++;
    step(); #1;
    total++;
    if (wb_ack !== 1'b0 || wb_dat_sm !== 32'd4)
      $display("FAIL ws_gap2: got ack=%b dat=%h want 0/4", wb_ack, wb_dat_sm);
    else passed++;
    step(); wb_stb = 1'b1; wb_cti = 3'b111; #1;
    total++;
    if (wb_ack !== 1'b0) $display("FAIL ws_return: got %b want 0", wb_ack);
    else passed++;
    step(); #1;
    total++;
    if (wb_ack !== 1'b1 || wb_dat_sm !== 32'd4)
      $display("FAIL ws_beat2: got ack=%b dat=%h want 1/4", wb_ack, wb_dat_sm);
    else passed++;
    step(); #1;
    total++;
    if (wb_ack !== 1'b0) $display("FAIL ws_after_end: got %b want 0", wb_ack);
    else passed++;
    step();
    bus_idle();
  endtask

  task automatic test_addr_err();
`ifdef WB_BRAM_BURST_ERR_EN
    do_write("err_wr", 32'h80000000, 32'h11223344, 4'hF, 1'b1);
    do_read("err_w0_kept", 32'h0, 4'hF, 3'b000, 32'h0, 1'b0);
    do_read("err_rd", 32'h80000010, 4'hF, 3'b000, 32'h0, 1'b1);
`else
    do_write("alias_wr", 32'h80000000, 32'h11223344, 4'hF, 1'b0);
    do_read("alias_w0", 32'h0, 4'hF, 3'b000, 32'h11223344, 1'b0);
`endif
  endtask

  task automatic test_reset_mid_burst();
    step();
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 4'hF;
    wb_adr = 32'h14; wb_cti = 3'b010; wb_bte = 2'b00;
    #1;
    step(); #1;
    total++;
    if (wb_ack !== 1'b1 || wb_dat_sm !== 32'd5)
      $display("FAIL rmb_beat0: got ack=%b dat=%h want 1/5", wb_ack, wb_dat_sm);
    else passed++;
    step(); #1;
    total++;
    if (wb_ack !== 1'b1 || wb_dat_sm !== 32'd6)
      $display("FAIL rmb_beat1: got ack=%b dat=%h want 1/6", wb_ack, wb_dat_sm);
    else passed++;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (wb_ack !== 1'b0) $display("FAIL rmb_ack_drop: got %b want 0", wb_ack);
    else passed++;
    total++;
    if (wb_dat_sm !== 32'h0) $display("FAIL rmb_dat_clear: got %h want 0", wb_dat_sm);
    else passed++;
    step();
    bus_idle();
    #2 rst_n = 1'b1;
    do_read("rmb_post_read", 32'h1C, 4'hF, 3'b000, 32'd7, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_classic();
    test_no_double_ack();
    test_fill();
    test_wrap_bursts();
    test_linear_end();
    test_const_burst();
    test_wait_state();
    test_addr_err();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
